fx2_in_writer: RTL and testbench

Drains the on-chip loopback buffer toward the host. Pops 16-bit words from the first-word-fall-through sync FIFO and writes them into an FX2LP slave-FIFO IN endpoint, one word per clock. Frames the words into full packets, or short packets closed with PKTEND after an idle timeout. Sits between the loopback buffer's read port and the FPGA pins driving the FX2 FD bus, SLWR, PKTEND and FIFOADR.

---
 rtl/fx2_pkg.sv | 9 +
 rtl/fx2_in_writer.sv | 73 +++++++
 tb/tb_fx2_in_writer.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/fx2_pkg.sv
// fx2_pkg: shared state type and constants for the FX2LP slave-FIFO blocks
package fx2_pkg;
  typedef enum logic [1:0] {IDLE, WRITE, PKTEND, WAIT_FLAG} fx2_state_e;
  localparam logic [1:0] EP2_ADDR = 2'b00;
  localparam logic [1:0] EP4_ADDR = 2'b01;
  localparam logic [1:0] EP6_ADDR = 2'b10;
  localparam logic [1:0] EP8_ADDR = 2'b11;
  localparam int FD_W = 16;
endpackage

// File: rtl/fx2_in_writer.sv
// fx2_in_writer: drains a FWFT buffer into an FX2LP slave-FIFO IN endpoint, framing
// full packets and closing partial ones with PKTEND after an idle timeout
module fx2_in_writer
  import fx2_pkg::*;
#(
  parameter logic [1:0] EP_ADDR = EP6_ADDR,
  parameter int PKT_WORDS = 256,
  parameter int IDLE_TIMEOUT = 1024,
  parameter int FLAG_LAT = 4
) (
  input  logic            fifo_clk,
  input  logic            reset,
  input  logic [FD_W-1:0] fifo_dout,
  input  logic            fifo_empty,
  output logic            fifo_read_busy,
  input  logic            fx2_full_n,
  output logic [FD_W-1:0] fx2_fd,
  output logic            fx2_slwr_n,
  output logic            fx2_pktend_n,
  output logic            fx2_sloe_n,
  output logic [1:0]      fx2_fifoadr,
  output logic [15:0]     pkt_count,
  output logic            busy
);
  localparam int WW = $clog2(PKT_WORDS);
  localparam int IW = $clog2(IDLE_TIMEOUT);
  localparam int LW = FLAG_LAT > 1 ? $clog2(FLAG_LAT) : 1;
  fx2_state_e r_state, w_next;
  logic [WW-1:0] r_word_cnt;
  logic [IW-1:0] r_idle_cnt;
  logic [LW-1:0] r_lat_cnt;
  logic w_last, w_timeout, w_lat_done, w_commit;
  assign fifo_read_busy = r_state == WRITE && !fifo_empty;
  assign w_last = fifo_read_busy && r_word_cnt == WW'(PKT_WORDS - 1);
  // timeout only counts empty cycles, so fresh data always wins the tie
  assign w_timeout = r_state == WRITE && fifo_empty && r_idle_cnt == IW'(IDLE_TIMEOUT - 1);
  assign w_lat_done = r_lat_cnt == LW'(FLAG_LAT - 1);
  assign w_commit = w_last || r_state == PKTEND;
  assign fx2_sloe_n = 1'b1;
  assign fx2_fifoadr = EP_ADDR;
  assign busy = r_state != IDLE;
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = (!fifo_empty && fx2_full_n) ? WRITE : IDLE;
      WRITE:   w_next = w_last ? WAIT_FLAG : w_timeout ? PKTEND : WRITE;
      PKTEND:  w_next = WAIT_FLAG;
      default: w_next = w_lat_done ? IDLE : WAIT_FLAG;
    endcase
  end
  always_ff @(posedge fifo_clk or posedge reset)
    if (reset) r_state <= IDLE;
    else r_state <= w_next;
  always_ff @(posedge fifo_clk or posedge reset)
    if (reset) begin
      fx2_fd       <= '0;
      fx2_slwr_n   <= 1'b1;
      fx2_pktend_n <= 1'b1;
      pkt_count    <= '0;
      r_word_cnt   <= '0;
      r_idle_cnt   <= '0;
      r_lat_cnt    <= '0;
    end else begin
      fx2_slwr_n   <= !fifo_read_busy;
      fx2_pktend_n <= r_state != PKTEND;
      if (fifo_read_busy) fx2_fd <= fifo_dout;
      pkt_count    <= pkt_count + 16'(w_commit);
      r_word_cnt   <= w_commit ? '0 : fifo_read_busy ? r_word_cnt + 1'b1 : r_word_cnt;
      r_idle_cnt   <= (fifo_read_busy || r_state == PKTEND) ? '0 :
                      (r_state == WRITE && !w_timeout) ? r_idle_cnt + 1'b1 : r_idle_cnt;
      r_lat_cnt    <= r_state == WAIT_FLAG ? r_lat_cnt + 1'b1 : '0;
    end
endmodule

// File: tb/tb_fx2_in_writer.sv
// tb_fx2_in_writer: randomized scenarios against a word-stream/packet-arithmetic model
module tb_fx2_in_writer;
  localparam int PKT = 256, TMO = 1024, LAT = 4;
  logic clk = 0, rst = 1, full_n = 1;
  logic [15:0] fifo_dout, fx2_fd, pkt_count;
  logic fifo_empty, fifo_read_busy, fx2_slwr_n, fx2_pktend_n, fx2_sloe_n, busy;
  logic [1:0] fx2_fifoadr;
  logic [15:0] mem [2048];
  int rd = 0, wr = 0;
  logic [15:0] exp_w[$], wq[$];
  int wcyc[$], pe_cyc[$];
  int cyc = 0, pops = 0, n_checks = 0, n_pass = 0;

  fx2_in_writer dut (
    .fifo_clk(clk), .reset(rst), .fifo_dout(fifo_dout), .fifo_empty(fifo_empty),
    .fifo_read_busy(fifo_read_busy), .fx2_full_n(full_n), .fx2_fd(fx2_fd),
    .fx2_slwr_n(fx2_slwr_n), .fx2_pktend_n(fx2_pktend_n), .fx2_sloe_n(fx2_sloe_n),
    .fx2_fifoadr(fx2_fifoadr), .pkt_count(pkt_count), .busy(busy)
  );

  always #5 clk = ~clk;
  assign fifo_empty = rd == wr;
  assign fifo_dout = mem[rd[10:0]];
  always @(posedge clk) if (fifo_read_busy) rd <= rd + 1;

  task automatic step();
    @(negedge clk);
    cyc++;
    if (!fx2_slwr_n) begin wq.push_back(fx2_fd); wcyc.push_back(cyc); end
    if (!fx2_pktend_n) pe_cyc.push_back(cyc);
    if (fifo_read_busy) pops++;
  endtask

  task automatic push(input logic [15:0] v);
    mem[wr[10:0]] = v;
    wr++;
    exp_w.push_back(v);
  endtask

  task automatic start(input logic fl);
    rst = 1;
    full_n = fl;
    wr = rd;
    repeat (3) step();
    exp_w.delete(); wq.delete(); wcyc.delete(); pe_cyc.delete();
    pops = 0;
    rst = 0;
    step();
  endtask

  task automatic wait_pktend(input int lim);
    int n = 0;
    while (pe_cyc.size() == 0 && n < lim) begin step(); n++; end
    repeat (8) step();
  endtask

  task automatic test_reset();
    rst = 1; full_n = 1;
    repeat (3) step();
    n_checks++; if (fx2_fd !== 16'h0 || busy !== 1'b0) $display("FAIL reset_fd_busy: fd=%h busy=%b want 0000/0", fx2_fd, busy); else n_pass++;
    rst = 0; pops = 0;
    repeat (100) step();
    n_checks++; if (fx2_slwr_n !== 1'b1 || fx2_pktend_n !== 1'b1) $display("FAIL reset_strobes: slwr=%b pktend=%b want 1/1", fx2_slwr_n, fx2_pktend_n); else n_pass++;
    n_checks++; if (pkt_count !== 16'd0 || busy !== 1'b0) $display("FAIL reset_count_busy: cnt=%0d busy=%b want 0/0", pkt_count, busy); else n_pass++;
    n_checks++; if (pops !== 0) $display("FAIL reset_no_pop: pops=%0d want 0", pops); else n_pass++;
    n_checks++; if (fx2_sloe_n !== 1'b1 || fx2_fifoadr !== 2'b10) $display("FAIL reset_consts: sloe=%b adr=%b want 1/10", fx2_sloe_n, fx2_fifoadr); else n_pass++;
  endtask

  task automatic test_full_packet();
    int n = 0, run = 0, wf = 0, bad = 0;
    start(1'b1);
    for (int i = 0; i < PKT; i++) push(16'(i));
    while (!fifo_read_busy && n < 50) begin step(); n++; end
    while (fifo_read_busy && run < 400) begin run++; step(); end
    while (busy && wf < 50) begin wf++; step(); end
    repeat (4) step();
    n_checks++; if (run !== PKT) $display("FAIL full_pop_run: %0d want %0d", run, PKT); else n_pass++;
    n_checks++; if (wf !== LAT) $display("FAIL full_wait_flag: %0d want %0d", wf, LAT); else n_pass++;
    n_checks++; if (wq.size() !== PKT) $display("FAIL full_write_count: %0d want %0d", wq.size(), PKT); else n_pass++;
    for (int i = 0; i < PKT; i++) if (wq[i] !== exp_w[i]) bad++;
    n_checks++; if (bad != 0) $display("FAIL full_data: %0d words differ, w0 got %h want %h", bad, wq[0], exp_w[0]); else n_pass++;
    n_checks++; if (wcyc[PKT-1] - wcyc[0] !== PKT - 1) $display("FAIL full_burst_span: %0d want %0d", wcyc[PKT-1] - wcyc[0], PKT - 1); else n_pass++;
    n_checks++; if (pe_cyc.size() !== 0 || pkt_count !== 16'd1) $display("FAIL full_commit: pktends=%0d cnt=%0d want 0/1", pe_cyc.size(), pkt_count); else n_pass++;
  endtask

  task automatic test_short_packet();
    int bad = 0;
    start(1'b1);
    for (int i = 0; i < 10; i++) push(16'($urandom_range(1, 65535)));
    wait_pktend(3000);
    n_checks++; if (wq.size() !== 10) $display("FAIL short_write_count: %0d want 10", wq.size()); else n_pass++;
    for (int i = 0; i < 10; i++) if (wq[i] !== exp_w[i]) bad++;
    n_checks++; if (bad != 0) $display("FAIL short_data: %0d words differ, w0 got %h want %h", bad, wq[0], exp_w[0]); else n_pass++;
    n_checks++; if (pe_cyc.size() !== 1) $display("FAIL short_pktend_pulses: %0d want 1", pe_cyc.size()); else n_pass++;
    n_checks++; if (pe_cyc[0] - wcyc[9] !== TMO + 1) $display("FAIL short_timeout_gap: %0d want %0d", pe_cyc[0] - wcyc[9], TMO + 1); else n_pass++;
    n_checks++; if (pkt_count !== 16'd1) $display("FAIL short_count: %0d want 1", pkt_count); else n_pass++;
  endtask

  task automatic test_flag_hold();
    int bad = 0;
    int total = 300;
    start(1'b0);
    for (int i = 0; i < total; i++) push(16'($urandom_range(1, 65535)));
    repeat (50) step();
    n_checks++; if (pops !== 0 || busy !== 1'b0) $display("FAIL flag_hold_no_pop: pops=%0d busy=%b want 0/0", pops, busy); else n_pass++;
    full_n = 1;
    wait_pktend(4000);
    n_checks++; if (wq.size() !== total) $display("FAIL flag_write_count: %0d want %0d", wq.size(), total); else n_pass++;
    for (int i = 0; i < total; i++) if (wq[i] !== exp_w[i]) bad++;
    n_checks++; if (bad != 0) $display("FAIL flag_data: %0d words differ", bad); else n_pass++;
    n_checks++; if (wcyc[PKT] - wcyc[PKT-1] !== LAT + 2) $display("FAIL flag_turnaround: %0d want %0d", wcyc[PKT] - wcyc[PKT-1], LAT + 2); else n_pass++;
    n_checks++; if (wcyc[total-1] - wcyc[PKT] !== total - PKT - 1) $display("FAIL flag_second_burst: %0d want %0d", wcyc[total-1] - wcyc[PKT], total - PKT - 1); else n_pass++;
    n_checks++; if (pe_cyc.size() !== 1 || pe_cyc[0] - wcyc[total-1] !== TMO + 1) $display("FAIL flag_pktend: n=%0d gap=%0d want 1/%0d", pe_cyc.size(), pe_cyc[0] - wcyc[total-1], TMO + 1); else n_pass++;
    n_checks++; if (pkt_count !== 16'((total + PKT - 1) / PKT)) $display("FAIL flag_count: %0d want %0d", pkt_count, (total + PKT - 1) / PKT); else n_pass++;
  endtask

  task automatic test_trickle();
    int bad = 0;
    int nw = int'($urandom_range(3, 5));
    start(1'b1);
    for (int i = 0; i < nw; i++) begin
      push(16'($urandom_range(1, 65535)));
      repeat ($urandom_range(200, 1000)) step();
    end
    n_checks++; if (pe_cyc.size() !== 0 || pkt_count !== 16'd0) $display("FAIL trickle_no_early_end: pktends=%0d cnt=%0d want 0/0", pe_cyc.size(), pkt_count); else n_pass++;
    wait_pktend(3000);
    n_checks++; if (wq.size() !== nw) $display("FAIL trickle_write_count: %0d want %0d", wq.size(), nw); else n_pass++;
    for (int i = 0; i < nw; i++) if (wq[i] !== exp_w[i]) bad++;
    n_checks++; if (bad != 0) $display("FAIL trickle_data: %0d words differ", bad); else n_pass++;
    n_checks++; if (pe_cyc.size() !== 1 || pe_cyc[0] - wcyc[nw-1] !== TMO + 1) $display("FAIL trickle_pktend: n=%0d gap=%0d want 1/%0d", pe_cyc.size(), pe_cyc[0] - wcyc[nw-1], TMO + 1); else n_pass++;
    n_checks++; if (pkt_count !== 16'd1) $display("FAIL trickle_count: %0d want 1", pkt_count); else n_pass++;
  endtask

  task automatic test_reset_mid_burst();
    int n = 0, bad = 0;
    int cut = PKT + 100, rest = 200;
    start(1'b1);
    for (int i = 0; i < cut + rest; i++) push(16'($urandom_range(1, 65535)));
    while (wq.size() < cut && n < 1000) begin step(); n++; end
    n_checks++; if (pkt_count !== 16'd1 || fx2_slwr_n !== 1'b0) $display("FAIL mid_before: cnt=%0d slwr=%b want 1/0", pkt_count, fx2_slwr_n); else n_pass++;
    rst = 1;
    #1;
    n_checks++; if (fx2_slwr_n !== 1'b1 || fx2_pktend_n !== 1'b1 || fx2_fd !== 16'h0) $display("FAIL mid_reset_pins: slwr=%b pktend=%b fd=%h want 1/1/0000", fx2_slwr_n, fx2_pktend_n, fx2_fd); else n_pass++;
    n_checks++; if (pkt_count !== 16'd0 || busy !== 1'b0 || fifo_read_busy !== 1'b0) $display("FAIL mid_reset_state: cnt=%0d busy=%b pop=%b want 0/0/0", pkt_count, busy, fifo_read_busy); else n_pass++;
    step();
    rst = 0;
    wq.delete(); wcyc.delete(); pe_cyc.delete();
    wait_pktend(4000);
    n_checks++; if (wq.size() !== rest) $display("FAIL mid_after_count: %0d want %0d", wq.size(), rest); else n_pass++;
    for (int i = 0; i < rest; i++) if (wq[i] !== exp_w[cut + i]) bad++;
    n_checks++; if (bad != 0) $display("FAIL mid_after_data: %0d words differ", bad); else n_pass++;
    n_checks++; if (wcyc[rest-1] - wcyc[0] !== rest - 1) $display("FAIL mid_after_span: %0d want %0d", wcyc[rest-1] - wcyc[0], rest - 1); else n_pass++;
    n_checks++; if (pe_cyc.size() !== 1 || pkt_count !== 16'd1) $display("FAIL mid_after_commit: pktends=%0d cnt=%0d want 1/1", pe_cyc.size(), pkt_count); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_full_packet();
    test_short_packet();
    test_flag_hold();
    test_trickle();
    test_reset_mid_burst();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
